// File: rtl/pcomp_pkg.sv
// Shared definitions for the p-computing blocks: activation range, LFSR
// constants and the sampler FSM encoding.
package pcomp_pkg;

  localparam int          ACT_W         = 4;
  localparam logic [3:0]  ACT_MID       = 4'd8;
  localparam logic [3:0]  ACT_MAX       = 4'd15;
  localparam logic [15:0] LFSR_MASK     = 16'hB400;
  localparam logic [15:0] LFSR_DEF_SEED = 16'hACE1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} sampler_state_t;

  // One right-shifting Galois step for x^16+x^14+x^13+x^11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with enable; reloads the seed on reset so every run
// after reset replays the same random stream.
module lfsr16
  import pcomp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= seed;
    else if (en) q <= lfsr_step(q);
  end

endmodule

// File: rtl/pbit_sampler.sv
// Sequential Gibbs sampler: updates one p-bit per RUN cycle in round-robin
// order by comparing the gate activation against a 4-bit random draw.
module pbit_sampler
  import pcomp_pkg::*;
#(
  parameter int          N     = 5,
  parameter int          ACT_W = 4,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          SW_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SW_W-1:0]        sweeps,
  input  logic [N*ACT_W-1:0]     act,
  input  logic [N-1:0]           clamp_mask,
  input  logic [N-1:0]           clamp_val,
  output logic [N-1:0]           state,
  output logic [$clog2(N)-1:0]   idx,
  output logic                   busy,
  output logic                   done,
  output logic [SW_W-1:0]        sweep_cnt
);

  localparam int          IDX_W    = $clog2(N);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? LFSR_DEF_SEED : SEED;

  if (ACT_W != pcomp_pkg::ACT_W) begin : g_act_w_check
    $error("pbit_sampler: ACT_W must be 4");
  end
  if (N < 2 || N > 32) begin : g_n_check
    $error("pbit_sampler: N must be in 2..32");
  end

  sampler_state_t    fsm;
  logic [SW_W-1:0]   target;
  logic [15:0]       lfsr_q;
  logic [ACT_W-1:0]  act_sel;
  logic              sample;
  logic              last;
  logic [SW_W-1:0]   cnt_inc;
  logic [N-1:0]      state_d;

  // The random stream only moves on RUN cycles, so a run is reproducible.
  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (fsm == RUN),
    .seed (SEED_EFF),
    .q    (lfsr_q)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    act_sel = act[idx*ACT_W +: ACT_W];
    sample  = (lfsr_q[ACT_W-1:0] < act_sel);
    last    = (idx == IDX_W'(N - 1));
    cnt_inc = sweep_cnt + 1'b1;
    state_d = state;
    if (fsm == RUN) state_d[idx] = sample;
    // Clamps override sampling in every state, so clamped index still
    // costs a RUN cycle but never changes.
    state_d = (state_d & ~clamp_mask) | (clamp_val & clamp_mask);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      state     <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sweep_cnt <= '0;
      target    <= '0;
    end else begin
      state <= state_d;
      done  <= 1'b0;
      unique case (fsm)
        IDLE: begin
          if (start) begin
            target    <= sweeps;
            sweep_cnt <= '0;
            idx       <= '0;
            if (sweeps == '0) begin
              fsm  <= FIN;
              done <= 1'b1;
            end else begin
              fsm  <= RUN;
              busy <= 1'b1;
            end
          end
        end
        RUN: begin
          if (last) begin
            idx       <= '0;
            sweep_cnt <= cnt_inc;
            if (cnt_inc == target) begin
              fsm  <= FIN;
              busy <= 1'b0;
              done <= 1'b1;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIN:     fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
